// File: rtl/clint_ctrl_pkg.sv
// Shared constants for the core-local interrupt controller: CSR addresses,
// system instruction encodings and mstatus bit positions.
package clint_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [1:0]  PRIV_M       = 2'b11;

  function automatic logic [31:0] csr_addr(input logic [11:0] a);
    return {20'h0, a};
  endfunction

endpackage

// File: rtl/clint_ctrl.sv
// Trap/mret sequencer: writes mepc/mcause/mstatus through the CSR clint port
// while holding the pipeline, then strobes a PC redirect.
//
// state        | meaning
// S_IDLE       | watching ID for ecall/ebreak/mret and external interrupts
// S_W_MEPC     | writing the latched PC to mepc
// S_W_MCAUSE   | writing the latched cause to mcause
// S_W_MSTATUS  | trap mstatus update, switch to machine mode
// S_ASSERT     | redirect to mtvec
// S_W_MRET     | mret mstatus update, restore privilege from MPP
// S_ASSERT_MRET| redirect to mepc
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int          INT_W     = 8,
  parameter logic [31:0] INT_CAUSE = 32'h8000_000B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INT_W-1:0] int_flag_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             jump_flag_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic [31:0]      csr_mtvec_i,
  input  logic [31:0]      csr_mepc_i,
  input  logic [31:0]      csr_mstatus_i,
  input  logic [1:0]       privilege_i,
  output logic             we_o,
  output logic [31:0]      waddr_o,
  output logic [31:0]      wdata_o,
  output logic             priv_we_o,
  output logic [1:0]       priv_o,
  output logic             hold_flag_o,
  output logic             int_assert_o,
  output logic [31:0]      int_addr_o
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_W_MEPC      = 3'd1;
  localparam logic [2:0] S_W_MCAUSE    = 3'd2;
  localparam logic [2:0] S_W_MSTATUS   = 3'd3;
  localparam logic [2:0] S_ASSERT      = 3'd4;
  localparam logic [2:0] S_W_MRET      = 3'd5;
  localparam logic [2:0] S_ASSERT_MRET = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, cause_q, mst_q;
  logic        in_idle, is_ecall, is_ebreak, is_mret;
  logic        sync_req, mret_req, async_req;
  logic [31:0] mst_trap, mst_mret;

  assign in_idle   = (state_q == S_IDLE);
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);

  // A redirecting EX means the instruction in ID is squashed, so only
  // asynchronous interrupts may be taken that cycle.
  assign sync_req  = in_idle & (is_ecall | is_ebreak) & ~jump_flag_i;
  assign mret_req  = in_idle & is_mret & ~jump_flag_i & ~sync_req;
  assign async_req = in_idle & (|int_flag_i) & csr_mstatus_i[MSTATUS_MIE] & ~hold_flag_i
                     & ~sync_req & ~mret_req;

  assign hold_flag_o = rst_n & (~in_idle | sync_req | mret_req | async_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      cause_q <= '0;
      mst_q   <= '0;
    end else if (sync_req) begin
      pc_q    <= inst_addr_i;
      cause_q <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
      mst_q   <= csr_mstatus_i;
    end else if (async_req) begin
      pc_q    <= jump_flag_i ? jump_addr_i : inst_addr_i;
      cause_q <= INT_CAUSE;
      mst_q   <= csr_mstatus_i;
    end else if (mret_req) begin
      mst_q   <= csr_mstatus_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (sync_req | async_req) state_d = S_W_MEPC;
        else if (mret_req)        state_d = S_W_MRET;
      end
      S_W_MEPC:      state_d = S_W_MCAUSE;
      S_W_MCAUSE:    state_d = S_W_MSTATUS;
      S_W_MSTATUS:   state_d = S_ASSERT;
      S_ASSERT:      state_d = S_IDLE;
      S_W_MRET:      state_d = S_ASSERT_MRET;
      S_ASSERT_MRET: state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mst_trap = mst_q;
    mst_trap[MSTATUS_MPIE] = mst_q[MSTATUS_MIE];
    mst_trap[MSTATUS_MIE]  = 1'b0;
    mst_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = privilege_i;
    mst_mret = mst_q;
    mst_mret[MSTATUS_MIE]  = mst_q[MSTATUS_MPIE];
    mst_mret[MSTATUS_MPIE] = 1'b1;
    mst_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  always_comb begin
    we_o         = 1'b0;
    waddr_o      = '0;
    wdata_o      = '0;
    priv_we_o    = 1'b0;
    priv_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (state_q)
      S_W_MEPC: begin
        we_o    = 1'b1;
        waddr_o = csr_addr(CSR_MEPC);
        wdata_o = pc_q;
      end
      S_W_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = csr_addr(CSR_MCAUSE);
        wdata_o = cause_q;
      end
      S_W_MSTATUS: begin
        we_o      = 1'b1;
        waddr_o   = csr_addr(CSR_MSTATUS);
        wdata_o   = mst_trap;
        priv_we_o = 1'b1;
        priv_o    = PRIV_M;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mtvec_i;
      end
      S_W_MRET: begin
        we_o      = 1'b1;
        waddr_o   = csr_addr(CSR_MSTATUS);
        wdata_o   = mst_mret;
        priv_we_o = 1'b1;
        priv_o    = mst_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end
      S_ASSERT_MRET: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Scoreboard bench for clint_ctrl: stimulus queues expected CSR-port/redirect
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_clint_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] ICAUSE = 32'h8000_000B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, hold_flag_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic [1:0]  privilege_i;
  logic        we_o, priv_we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, wdata_o, int_addr_o;
  logic [1:0]  priv_o;

  clint_ctrl #(.INT_W(8), .INT_CAUSE(32'h8000_000B)) dut (
    .clk(clk), .rst_n(rst_n), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_mstatus_i(csr_mstatus_i), .privilege_i(privilege_i), .we_o(we_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .priv_we_o(priv_we_o), .priv_o(priv_o),
    .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  // {we, waddr, wdata, priv_we, priv, int_assert, int_addr}
  typedef logic [100:0] ev_t;
  ev_t   exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic ev_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                             input logic pwe, input logic [1:0] pv, input logic ia,
                             input logic [31:0] iaddr);
    return {we, wa, wd, pwe, pv, ia, iaddr};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input string nm, input ev_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic push_trap(input string nm, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] mst);
    expect_ev({nm, "_mepc"},    mk(1'b1, 32'h341, pc,    1'b0, 2'b00, 1'b0, 32'h0));
    expect_ev({nm, "_mcause"},  mk(1'b1, 32'h342, cause, 1'b0, 2'b00, 1'b0, 32'h0));
    expect_ev({nm, "_mstatus"}, mk(1'b1, 32'h300, mst,   1'b1, 2'b11, 1'b0, 32'h0));
    expect_ev({nm, "_assert"},  mk(1'b0, 32'h0,   32'h0, 1'b0, 2'b00, 1'b1, 32'h200));
  endtask

  always @(negedge clk) begin
    ev_t   act;
    ev_t   e;
    string nm;
    if (rst_n) begin
      n_cmp++;
      if (!int_assert_o && int_addr_o !== 32'h0) begin
        n_err++;
        $display("FAIL idle_int_addr: got %h expected 00000000", int_addr_o);
      end
      if (we_o || priv_we_o || int_assert_o) begin
        act = {we_o, waddr_o, wdata_o, priv_we_o, priv_o, int_assert_o, int_addr_o};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got %h expected none", act);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_assert(input int exp_lat, input string nm, input logic [31:0] mst_after);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      inst_i      = NOP;
      jump_flag_i = 1'b0;
      if (i == 0) csr_mstatus_i = mst_after;
      if (int_assert_o) break;
    end
    check(nm, n, exp_lat);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_we"},     {31'h0, we_o}, 32'h0);
    check({nm, "_waddr"},  waddr_o, 32'h0);
    check({nm, "_wdata"},  wdata_o, 32'h0);
    check({nm, "_priv"},   {29'h0, priv_we_o, priv_o}, 32'h0);
    check({nm, "_hold"},   {31'h0, hold_flag_o}, 32'h0);
    check({nm, "_assert"}, {31'h0, int_assert_o}, 32'h0);
    check({nm, "_iaddr"},  int_addr_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; int_flag_i = '0; inst_i = NOP; inst_addr_i = '0;
    jump_flag_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0;
    csr_mtvec_i = 32'h200; csr_mepc_i = '0; csr_mstatus_i = '0; privilege_i = 2'b11;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 1: ecall
    inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8;
    #1 check("t1_hold", {31'h0, hold_flag_o}, 32'h1);
    push_trap("t1", 32'h100, 32'd11, 32'h1880);
    wait_assert(4, "t1_latency", 32'h1880);
    tick();
    check("t1_idle_hold", {31'h0, hold_flag_o}, 32'h0);

    // 2: mret
    inst_i = MRET; csr_mepc_i = 32'h104; csr_mstatus_i = 32'h1880;
    #1 check("t2_hold", {31'h0, hold_flag_o}, 32'h1);
    expect_ev("t2_mstatus", mk(1'b1, 32'h300, 32'h88, 1'b1, 2'b11, 1'b0, 32'h0));
    expect_ev("t2_assert",  mk(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 32'h104));
    wait_assert(2, "t2_latency", 32'h88);
    check("t2_hold_assert", {31'h0, hold_flag_o}, 32'h1);
    tick();
    check("t2_hold_done", {31'h0, hold_flag_o}, 32'h0);

    // 3: interrupt masked, then taken, then taken with EX redirect
    csr_mstatus_i = 32'h0; int_flag_i = 8'h01; inst_addr_i = 32'h120;
    #1 check("t3_masked_hold", {31'h0, hold_flag_o}, 32'h0);
    tick(); tick();
    check("t3_masked_hold2", {31'h0, hold_flag_o}, 32'h0);
    csr_mstatus_i = 32'h8;
    #1 check("t3_hold", {31'h0, hold_flag_o}, 32'h1);
    push_trap("t3", 32'h120, ICAUSE, 32'h1880);
    wait_assert(4, "t3_latency", 32'h1880);
    tick();
    check("t3_pending_hold", {31'h0, hold_flag_o}, 32'h0);
    csr_mstatus_i = 32'h8; jump_flag_i = 1'b1; jump_addr_i = 32'h300;
    #1 check("t3j_hold", {31'h0, hold_flag_o}, 32'h1);
    push_trap("t3j", 32'h300, ICAUSE, 32'h1880);
    wait_assert(4, "t3j_latency", 32'h1880);
    tick();
    int_flag_i = '0;

    // 4: ecall beats interrupt; interrupt taken right after mret
    inst_i = ECALL; inst_addr_i = 32'h140; int_flag_i = 8'h80; csr_mstatus_i = 32'h8;
    #1;
    push_trap("t4", 32'h140, 32'd11, 32'h1880);
    wait_assert(4, "t4_latency", 32'h1880);
    tick();
    check("t4_pending_hold", {31'h0, hold_flag_o}, 32'h0);
    inst_i = MRET; inst_addr_i = 32'h148; csr_mepc_i = 32'h144;
    #1;
    expect_ev("t4_mret_mstatus", mk(1'b1, 32'h300, 32'h88, 1'b1, 2'b11, 1'b0, 32'h0));
    expect_ev("t4_mret_assert",  mk(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 32'h144));
    push_trap("t4i", 32'h148, ICAUSE, 32'h1880);
    wait_assert(2, "t4_mret_latency", 32'h88);
    tick();
    check("t4i_hold", {31'h0, hold_flag_o}, 32'h1);
    wait_assert(4, "t4i_latency", 32'h1880);
    tick();
    int_flag_i = '0;

    // 5: EX busy blocks interrupt entry
    hold_flag_i = 1'b1; int_flag_i = 8'h10; csr_mstatus_i = 32'h8; inst_addr_i = 32'h160;
    #1 check("t5_blocked", {31'h0, hold_flag_o}, 32'h0);
    tick();
    check("t5_blocked2", {31'h0, hold_flag_o}, 32'h0);
    hold_flag_i = 1'b0;
    #1 check("t5_hold", {31'h0, hold_flag_o}, 32'h1);
    push_trap("t5", 32'h160, ICAUSE, 32'h1880);
    wait_assert(4, "t5_latency", 32'h1880);
    tick();
    int_flag_i = '0;

    // 6: reset during the mcause write
    inst_i = ECALL; inst_addr_i = 32'h180; csr_mstatus_i = 32'h8;
    #1;
    expect_ev("t6_mepc", mk(1'b1, 32'h341, 32'h180, 1'b0, 2'b00, 1'b0, 32'h0));
    tick();
    inst_i = NOP;
    tick();
    check("t6_pre_we", {31'h0, we_o}, 32'h1);
    check("t6_pre_waddr", waddr_o, 32'h342);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_all_zero("t6_idle");
    inst_i = EBREAK; inst_addr_i = 32'h1a0; csr_mstatus_i = 32'h8;
    #1;
    push_trap("t6b", 32'h1a0, 32'd3, 32'h1880);
    wait_assert(4, "t6b_latency", 32'h1880);
    tick();

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
